// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of an 8N1/8N2 serializer.
// Baud divider, stop-bit count and enable are sampled at each frame start.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIV_W-1:0]         cfg_div,
  input  logic                     cfg_txen,
  input  logic                     cfg_nstop,
  input  logic                     tx_valid,
  input  logic [7:0]               tx_data,
  output logic                     tx_ready,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   tx_level,
  output logic                     uart_txd
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      level_reg;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] baud_reg, baud_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic             nstop_reg, nstop_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             txd_reg, txd_next;

  logic push, pop, load, can_start, baud_tick;

  assign tx_ready  = (level_reg != FULL_LVL);
  assign push      = tx_valid && tx_ready;
  assign can_start = (level_reg != '0) && cfg_txen;
  assign baud_tick = (baud_reg == div_reg);
  assign tx_busy   = (state_reg != IDLE);
  assign tx_level  = level_reg;
  assign uart_txd  = txd_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= tx_data;
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    div_next   = div_reg;
    nstop_next = nstop_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    load       = 1'b0;

    if (state_reg != IDLE) begin
      baud_next = baud_tick ? '0 : baud_reg + DIV_W'(1);
    end

    case (state_reg)
      IDLE: load = can_start;
      START: begin
        if (baud_tick) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      STOP: begin
        // bit_reg counts stop bits already sent; last one ends at index nstop
        if (baud_tick) begin
          if (bit_reg == {2'b00, nstop_reg}) begin
            state_next = IDLE;
            load       = can_start;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      shift_next = mem[rd_ptr_reg];
      div_next   = cfg_div;
      nstop_next = cfg_nstop;
      baud_next  = '0;
      bit_next   = '0;
      state_next = START;
    end
    pop = load;

    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      state_reg  <= IDLE;
      baud_reg   <= '0;
      div_reg    <= '0;
      nstop_reg  <= 1'b0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      txd_reg    <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_ONE;
        2'b01:   level_reg <= level_reg - LVL_ONE;
        default: level_reg <= level_reg;
      endcase
      state_reg <= state_next;
      baud_reg  <= baud_next;
      div_reg   <= div_next;
      nstop_reg <= nstop_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: line monitor decodes frames against a byte scoreboard,
// table of single-frame vectors plus directed sequences for FIFO/reset/config corners.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int DIV_W = 16;

  logic clk = 1'b0;
  logic rst, cfg_txen, cfg_nstop, tx_valid;
  logic [DIV_W-1:0] cfg_div;
  logic [7:0] tx_data;
  logic tx_ready, tx_busy, uart_txd;
  logic [$clog2(DEPTH):0] tx_level;

  uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_txen(cfg_txen),
    .cfg_nstop(cfg_nstop), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_level(tx_level),
    .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard and monitor state
  logic [7:0] exp_q[$];
  int starts_q[$];
  int ends_q[$];
  int frames_done = 0;
  int mon_div = 3;
  bit mon_nstop = 1'b0;
  bit mon_kill = 1'b0;

  int m_d, m_nb, m_start;
  bit m_abort, m_glitch;
  logic [10:0] m_bits;
  logic [7:0] m_exp;

  always begin : monitor
    @(negedge clk);
    if (!mon_kill && uart_txd === 1'b0) begin
      m_d = mon_div;
      m_nb = 10 + int'(mon_nstop);
      m_start = cyc;
      m_abort = 1'b0;
      m_glitch = 1'b0;
      m_bits = '1;
      for (int b = 0; b < m_nb && !m_abort; b++) begin
        for (int c = 0; c <= m_d && !m_abort; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (mon_kill) m_abort = 1'b1;
          else if (c == 0) m_bits[b] = uart_txd;
          else if (uart_txd !== m_bits[b]) m_glitch = 1'b1;
        end
      end
      if (!m_abort) begin
        chk("bit_stable", m_glitch, 1'b0);
        chk("start_bit", m_bits[0], 1'b0);
        chk("stop_bits", (m_nb == 11) ? {m_bits[10], m_bits[9]} : {1'b1, m_bits[9]}, 2'b11);
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", m_bits[8:1], 32'hFFFF_FFFF);
        end else begin
          m_exp = exp_q.pop_front();
          chk("frame_data", m_bits[8:1], m_exp);
          $display("frame %0d: data %02h expected %02h start %0d end %0d",
                   frames_done, m_bits[8:1], m_exp, m_start, cyc);
        end
        starts_q.push_back(m_start);
        ends_q.push_back(cyc);
        frames_done++;
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         nstop;
    int         exp_len;
  } vec_t;
  vec_t vecs [5];

  task automatic push_now(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data = b;
    exp_q.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int limit, input string name);
    int n = 0;
    while (frames_done < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, frames_done >= target, 1'b1);
  endtask

  task automatic set_cfg(input int d, input bit ns);
    cfg_div = DIV_W'(d);
    cfg_nstop = ns;
    mon_div = d;
    mon_nstop = ns;
  endtask

  initial begin : global_timeout
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t0, n, base, exp_lvl;
    rst = 1'b1; cfg_txen = 1'b1; tx_valid = 1'b0; tx_data = '0;
    set_cfg(3, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_level", tx_level, 0);
    chk("rst_ready", tx_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // first-byte latency and frame end, div=3 8N1
    t0 = cyc;
    push_now(8'h55);
    chk("lat_idle", uart_txd, 1'b1);
    @(negedge clk);
    chk("lat_cycle", cyc - t0, 2);
    chk("lat_start", uart_txd, 1'b0);
    chk("lat_busy", tx_busy, 1'b1);
    while (cyc < t0 + 41) @(negedge clk);
    chk("end_busy41", tx_busy, 1'b1);
    @(negedge clk);
    chk("end_busy42", tx_busy, 1'b0);
    chk("end_txd42", uart_txd, 1'b1);
    wait_frames(1, 20, "first_frame_timeout");

    // table of single frames: frame length measured on tx_busy
    vecs[0] = '{8'hA3, 3, 1'b1, 44};
    vecs[1] = '{8'h00, 1, 1'b0, 20};
    vecs[2] = '{8'hFF, 0, 1'b1, 11};
    vecs[3] = '{8'h5A, 2, 1'b1, 33};
    vecs[4] = '{8'h81, 5, 1'b0, 60};
    for (int i = 0; i < 5; i++) begin
      set_cfg(vecs[i].div, vecs[i].nstop);
      base = frames_done;
      @(negedge clk);
      push_now(vecs[i].data);
      n = 0;
      while (tx_busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      n = 0;
      while (tx_busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
      chk("vec_len", n, vecs[i].exp_len);
      chk("vec_idle_txd", uart_txd, 1'b1);
      wait_frames(base + 1, 20, "vec_frame_timeout");
    end

    // fill FIFO with engine disabled, overflow pushes ignored
    set_cfg(1, 1'b0);
    cfg_txen = 1'b0;
    exp_lvl = 0;
    base = frames_done;
    for (int i = 0; i < 6; i++) begin
      chk("fill_ready", tx_ready, exp_lvl < DEPTH);
      tx_valid = 1'b1;
      tx_data = 8'(i + 1);
      if (exp_lvl < DEPTH) begin
        exp_q.push_back(8'(i + 1));
        exp_lvl++;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("full_level", tx_level, DEPTH);
    chk("full_ready", tx_ready, 1'b0);
    repeat (5) @(negedge clk);
    chk("disabled_busy", tx_busy, 1'b0);
    chk("disabled_txd", uart_txd, 1'b1);
    chk("disabled_level", tx_level, DEPTH);
    cfg_txen = 1'b1;
    wait_frames(base + 4, 400, "burst_timeout");
    for (int k = 1; k < 4; k++) chk("burst_gap", starts_q[base + k], ends_q[base + k - 1] + 1);
    repeat (20) @(negedge clk);
    chk("burst_count", frames_done, base + 4);
    chk("burst_level", tx_level, 0);
    chk("burst_q_empty", exp_q.size(), 0);

    // div=0 back-to-back
    set_cfg(0, 1'b0);
    base = frames_done;
    @(negedge clk);
    push_now(8'hFF);
    push_now(8'h00);
    wait_frames(base + 2, 100, "div0_timeout");
    chk("div0_len0", ends_q[base] - starts_q[base] + 1, 10);
    chk("div0_len1", ends_q[base + 1] - starts_q[base + 1] + 1, 10);
    chk("div0_gap", starts_q[base + 1], ends_q[base] + 1);

    // reset during data bit 3 discards the frame and the queued byte
    set_cfg(7, 1'b0);
    base = frames_done;
    @(negedge clk);
    t0 = cyc;
    push_now(8'h3C);
    push_now(8'h99);
    while (cyc < t0 + 36) @(negedge clk);
    chk("pre_rst_level", tx_level, 1);
    mon_kill = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_txd", uart_txd, 1'b1);
    chk("midrst_level", tx_level, 0);
    chk("midrst_busy", tx_busy, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    mon_kill = 1'b0;
    chk("midrst_no_frame", frames_done, base);
    push_now(8'h81);
    wait_frames(base + 1, 200, "post_rst_timeout");
    repeat (10) @(negedge clk);
    chk("post_rst_count", frames_done, base + 1);

    // config changes mid-frame are deferred to the next frame
    set_cfg(3, 1'b0);
    base = frames_done;
    @(negedge clk);
    push_now(8'hC6);
    push_now(8'h3B);
    repeat (6) @(negedge clk);
    cfg_div = 16'd9;
    mon_div = 9;
    cfg_txen = 1'b0;
    wait_frames(base + 1, 100, "cfgchg_timeout");
    chk("cfgchg_len_a", ends_q[base] - starts_q[base] + 1, 40);
    repeat (20) @(negedge clk);
    chk("cfgchg_busy", tx_busy, 1'b0);
    chk("cfgchg_level", tx_level, 1);
    chk("cfgchg_held", frames_done, base + 1);
    cfg_txen = 1'b1;
    wait_frames(base + 2, 200, "cfgchg_b_timeout");
    chk("cfgchg_len_b", ends_q[base + 1] - starts_q[base + 1] + 1, 100);

    repeat (5) @(negedge clk);
    chk("final_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
